mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_stage_pkg.sv | 28 ++
 rtl/bus_timeout_counter.sv | 38 +++
 rtl/mem_access_stage.sv | 120 ++++++++++++
 tb/tb_mem_access_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-access pipeline stage.
package mem_stage_pkg;

    localparam int DEFAULT_DATA_W  = 24;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_ALU   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_STORE = 2'd3
    } op_class_e;

    // A store wins over a register write; the writeback source selects load vs ALU.
    function automatic op_class_e decode_op(input logic mem_we, input logic reg_we,
                                            input logic from_alu);
        if (mem_we) return OP_STORE;
        if (reg_we) return from_alu ? OP_ALU : OP_LOAD;
        return OP_NOP;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles spent waiting on the memory bus; flags the last allowed cycle.
module bus_timeout_counter #(
    parameter int TIMEOUT = mem_stage_pkg::DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: ALU results pass straight to writeback, loads and stores
// run one bus transaction each with a bounded wait for the acknowledge.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              validIn,
    input  logic              memWe,
    input  logic              regWe,
    input  logic              writeRegFromAlu,
    input  logic [3:0]        regToWrite,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] dataToWrite,
    output logic              stall,
    output logic              memReq,
    output logic              memWrite,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata,
    input  logic              memAck,
    output logic              wbValid,
    output logic [3:0]        wbReg,
    output logic [DATA_W-1:0] wbData,
    output logic              busErr
);

    state_e            state_q;
    op_class_e         op_class;
    logic              expired;
    logic              mem_req_q;
    logic              mem_write_q;
    logic [DATA_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              wb_valid_q;
    logic [3:0]        wb_reg_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              bus_err_q;

    assign op_class = decode_op(memWe, regWe, writeRegFromAlu);

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != REQ),
        .enable  (state_q == REQ),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (validIn) begin
                        unique case (op_class)
                            OP_ALU: begin
                                wb_valid_q <= 1'b1;
                                wb_data_q  <= result;
                                wb_reg_q   <= regToWrite;
                            end
                            OP_LOAD, OP_STORE: begin
                                state_q     <= REQ;
                                mem_req_q   <= 1'b1;
                                mem_write_q <= (op_class == OP_STORE);
                                mem_addr_q  <= result;
                                mem_wdata_q <= dataToWrite;
                                wb_reg_q    <= regToWrite;
                            end
                            default: ;
                        endcase
                    end
                end
                REQ: begin
                    // An acknowledge on the final allowed cycle beats the timeout.
                    if (memAck) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        if (!mem_write_q) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= memRdata;
                        end
                    end else if (expired) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall    = (state_q == REQ);
    assign memReq   = mem_req_q;
    assign memWrite = mem_write_q;
    assign memAddr  = mem_addr_q;
    assign memWdata = mem_wdata_q;
    assign wbValid  = wb_valid_q;
    assign wbReg    = wb_reg_q;
    assign wbData   = wb_data_q;
    assign busErr   = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU, load, store, timeout, reset and back-to-back cases.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        validIn = 1'b0;
    logic        memWe = 1'b0;
    logic        regWe = 1'b0;
    logic        writeRegFromAlu = 1'b0;
    logic [3:0]  regToWrite = '0;
    logic [23:0] result = '0;
    logic [23:0] dataToWrite = '0;
    logic [23:0] memRdata = '0;
    logic        memAck = 1'b0;
    logic        stall;
    logic        memReq;
    logic        memWrite;
    logic [23:0] memAddr;
    logic [23:0] memWdata;
    logic        wbValid;
    logic [3:0]  wbReg;
    logic [23:0] wbData;
    logic        busErr;

    int vectors = 0;
    int miscompares = 0;

    mem_access_stage dut (
        .clk             (clk),
        .reset           (reset),
        .validIn         (validIn),
        .memWe           (memWe),
        .regWe           (regWe),
        .writeRegFromAlu (writeRegFromAlu),
        .regToWrite      (regToWrite),
        .result          (result),
        .dataToWrite     (dataToWrite),
        .stall           (stall),
        .memReq          (memReq),
        .memWrite        (memWrite),
        .memAddr         (memAddr),
        .memWdata        (memWdata),
        .memRdata        (memRdata),
        .memAck          (memAck),
        .wbValid         (wbValid),
        .wbReg           (wbReg),
        .wbData          (wbData),
        .busErr          (busErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic we_mem, input logic we_reg, input logic from_alu,
                           input logic [3:0] rd, input logic [23:0] res, input logic [23:0] wd);
        validIn         = 1'b1;
        memWe           = we_mem;
        regWe           = we_reg;
        writeRegFromAlu = from_alu;
        regToWrite      = rd;
        result          = res;
        dataToWrite     = wd;
    endtask

    task automatic idle_inputs();
        validIn = 1'b0;
        memWe   = 1'b0;
        regWe   = 1'b0;
        result  = 24'h5A5A5A;
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge
        #2 reset = 1'b1;
        #1;
        check("rst_memReq", memReq, 0);
        check("rst_memWrite", memWrite, 0);
        check("rst_stall", stall, 0);
        check("rst_wbValid", wbValid, 0);
        check("rst_busErr", busErr, 0);
        check("rst_memAddr", memAddr, 0);
        check("rst_memWdata", memWdata, 0);
        check("rst_wbData", wbData, 0);
        check("rst_wbReg", wbReg, 0);
        step();
        step();
        reset = 1'b0;

        // ALU op
        present(1'b0, 1'b1, 1'b1, 4'd5, 24'h00ABCD, 24'h0);
        check("alu_stall_pre", stall, 0);
        step();
        idle_inputs();
        check("alu_wbValid", wbValid, 1);
        check("alu_wbData", wbData, 24'h00ABCD);
        check("alu_wbReg", wbReg, 5);
        check("alu_stall", stall, 0);
        check("alu_memReq", memReq, 0);
        step();
        check("alu_wbValid_drop", wbValid, 0);

        // Nop, plus a stray memAck in IDLE
        present(1'b0, 1'b0, 1'b1, 4'd2, 24'h000111, 24'h0);
        memAck = 1'b1;
        step();
        idle_inputs();
        memAck = 1'b0;
        check("nop_memReq", memReq, 0);
        check("nop_wbValid", wbValid, 0);
        check("nop_stall", stall, 0);

        // Load, acknowledged on the third REQ cycle
        present(1'b0, 1'b1, 1'b0, 4'd7, 24'h000010, 24'h0);
        step();
        idle_inputs();
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("ld_memReq_c%0d", i), memReq, 1);
            check($sformatf("ld_memAddr_c%0d", i), memAddr, 24'h000010);
            check($sformatf("ld_stall_c%0d", i), stall, 1);
            check($sformatf("ld_wbValid_c%0d", i), wbValid, 0);
            if (i == 3) begin
                memAck   = 1'b1;
                memRdata = 24'h123456;
            end
            step();
        end
        memAck   = 1'b0;
        memRdata = 24'h0;
        check("ld_memReq_done", memReq, 0);
        check("ld_stall_done", stall, 0);
        check("ld_wbValid", wbValid, 1);
        check("ld_wbData", wbData, 24'h123456);
        check("ld_wbReg", wbReg, 7);
        step();
        check("ld_wbValid_drop", wbValid, 0);

        // Store, acknowledged on the first REQ cycle
        present(1'b1, 1'b1, 1'b0, 4'd3, 24'h000020, 24'hFFFFFF);
        step();
        idle_inputs();
        check("st_memReq", memReq, 1);
        check("st_memWrite", memWrite, 1);
        check("st_memWdata", memWdata, 24'hFFFFFF);
        check("st_memAddr", memAddr, 24'h000020);
        check("st_wbValid_req", wbValid, 0);
        memAck = 1'b1;
        step();
        memAck = 1'b0;
        check("st_memReq_done", memReq, 0);
        check("st_wbValid_done", wbValid, 0);
        step();
        check("st_wbValid_idle", wbValid, 0);

        // Load with no acknowledge: 15 REQ cycles then bus error
        present(1'b0, 1'b1, 1'b0, 4'd4, 24'h000030, 24'h0);
        step();
        idle_inputs();
        for (int i = 1; i <= 15; i++) begin
            check($sformatf("to_memReq_c%0d", i), memReq, 1);
            check($sformatf("to_busErr_c%0d", i), busErr, 0);
            step();
        end
        check("to_memReq_drop", memReq, 0);
        check("to_busErr_set", busErr, 1);
        check("to_wbValid", wbValid, 0);
        check("to_stall", stall, 0);
        step();
        check("to_busErr_sticky", busErr, 1);
        present(1'b0, 1'b1, 1'b1, 4'd3, 24'h000111, 24'h0);
        step();
        idle_inputs();
        check("to_alu_wbValid", wbValid, 1);
        check("to_alu_wbData", wbData, 24'h000111);
        check("to_alu_busErr", busErr, 1);
        step();

        // Reset in the second cycle of a REQ wait
        present(1'b0, 1'b1, 1'b0, 4'd6, 24'h000040, 24'h0);
        step();
        idle_inputs();
        step();
        check("rr_memReq_pre", memReq, 1);
        reset = 1'b1;
        #1;
        check("rr_memReq", memReq, 0);
        check("rr_stall", stall, 0);
        check("rr_busErr", busErr, 0);
        step();
        reset = 1'b0;
        memAck   = 1'b1;
        memRdata = 24'h999999;
        step();
        memAck = 1'b0;
        check("rr_ack_wbValid", wbValid, 0);
        check("rr_ack_memReq", memReq, 0);

        // Acknowledge on the same cycle the timeout would fire
        present(1'b0, 1'b1, 1'b0, 4'd8, 24'h000050, 24'h0);
        step();
        idle_inputs();
        for (int i = 1; i < 15; i++) step();
        check("ta_memReq_c15", memReq, 1);
        memAck   = 1'b1;
        memRdata = 24'hABCDEF;
        step();
        memAck = 1'b0;
        check("ta_wbValid", wbValid, 1);
        check("ta_wbData", wbData, 24'hABCDEF);
        check("ta_busErr", busErr, 0);
        step();

        // Back-to-back: ALU op presented in the load's DONE cycle
        present(1'b0, 1'b1, 1'b0, 4'd1, 24'h000060, 24'h0);
        step();
        idle_inputs();
        memAck   = 1'b1;
        memRdata = 24'h55AA55;
        step();
        memAck = 1'b0;
        check("bb_ld_wbValid", wbValid, 1);
        check("bb_ld_wbData", wbData, 24'h55AA55);
        check("bb_ld_wbReg", wbReg, 1);
        check("bb_done_stall", stall, 0);
        present(1'b0, 1'b1, 1'b1, 4'd9, 24'h000777, 24'h0);
        step();
        idle_inputs();
        check("bb_alu_wbValid", wbValid, 1);
        check("bb_alu_wbData", wbData, 24'h000777);
        check("bb_alu_wbReg", wbReg, 9);
        step();
        check("bb_wbValid_drop", wbValid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
